// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, issues sequential reads to a 1-cycle
// instruction memory and buffers responses in a credit-controlled FIFO.
module fetch_unit #(
  parameter int ADDR_W   = 10,
  parameter int INST_W   = 32,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0,
  parameter int PC_INC   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         imem_en,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic [INST_W-1:0]            imem_rdata,
  input  logic                         redirect,
  input  logic [ADDR_W-1:0]            redirect_pc,
  output logic                         inst_valid,
  input  logic                         inst_ready,
  output logic [INST_W-1:0]            inst_data,
  output logic [ADDR_W-1:0]            inst_pc,
  output logic [$clog2(DEPTH):0]       queue_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_p0;
  logic              vld_p1;
  logic [ADDR_W-1:0] pc_p1;

  logic [INST_W-1:0] q_data [DEPTH];
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [CNT_W:0]    used;
  logic              issue;
  logic              push;
  logic              pop;

  // Credit check counts the in-flight read so a response always has a free slot.
  always_comb begin
    used       = {1'b0, count} + (CNT_W+1)'(vld_p1);
    issue      = rst && !redirect && (used < (CNT_W+1)'(DEPTH));
    push       = rst && !redirect && vld_p1;
    inst_valid = rst && (count != '0);
    pop        = inst_valid && inst_ready;
  end

  assign imem_en     = issue;
  assign imem_addr   = pc_p0;
  assign inst_data   = q_data[rd_ptr];
  assign inst_pc     = q_pc[rd_ptr];
  assign queue_count = count;

  // ---- stage p0: PC and issue ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_p0 <= ADDR_W'(RESET_PC);
    end else if (redirect) begin
      pc_p0 <= redirect_pc;
    end else if (issue) begin
      pc_p0 <= pc_p0 + ADDR_W'(PC_INC);
    end
  end

  // ---- stage p1: outstanding read tracking ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= issue;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      pc_p1 <= pc_p0;
    end
  end

  // ---- stage p2: instruction queue ----
  always_ff @(posedge clk) begin
    if (!rst || redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]   <= pc_p1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed cycle table plus a randomized stream check for fetch_unit.
module tb_fetch_unit;
  localparam int ADDR_W = 10;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;
  localparam int NV     = 36;

  logic              clk = 1'b0;
  logic              rst;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic [2:0]        queue_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .RESET_PC(0), .PC_INC(4)) dut (
    .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .queue_count(queue_count)
  );

  // One-cycle memory returning a pattern derived from the address.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= 32'(imem_addr) ^ 32'hA5A5A5A5;
  end

  typedef struct {
    logic              rst;
    logic              redir;
    logic [ADDR_W-1:0] rpc;
    logic              rdy;
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic              valid;
    logic [ADDR_W-1:0] ipc;
    logic [2:0]        cnt;
  } vec_t;

  vec_t tbl [NV];

  function automatic vec_t mk(logic r, logic rd, logic [ADDR_W-1:0] rp, logic y, logic e,
                              logic [ADDR_W-1:0] a, logic vl, logic [ADDR_W-1:0] p, logic [2:0] c);
    vec_t t;
    t.rst = r; t.redir = rd; t.rpc = rp; t.rdy = y; t.en = e;
    t.addr = a; t.valid = vl; t.ipc = p; t.cnt = c;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    int delivered;
    logic [ADDR_W-1:0] exp_pc;

    //              rst rd rpc     rdy en addr    vld ipc     cnt
    tbl[0]  = mk(0, 0, 10'h000, 1, 0, 10'h000, 0, 10'h000, 3'd0);
    tbl[1]  = mk(1, 0, 10'h000, 1, 1, 10'h000, 0, 10'h000, 3'd0);
    tbl[2]  = mk(1, 0, 10'h000, 1, 1, 10'h004, 0, 10'h000, 3'd0);
    tbl[3]  = mk(1, 0, 10'h000, 1, 1, 10'h008, 1, 10'h000, 3'd1);
    tbl[4]  = mk(1, 0, 10'h000, 1, 1, 10'h00C, 1, 10'h004, 3'd1);
    tbl[5]  = mk(1, 0, 10'h000, 0, 1, 10'h010, 1, 10'h008, 3'd1);
    tbl[6]  = mk(1, 0, 10'h000, 0, 1, 10'h014, 1, 10'h008, 3'd2);
    tbl[7]  = mk(1, 0, 10'h000, 0, 0, 10'h018, 1, 10'h008, 3'd3);
    tbl[8]  = mk(1, 0, 10'h000, 0, 0, 10'h018, 1, 10'h008, 3'd4);
    tbl[9]  = mk(1, 0, 10'h000, 0, 0, 10'h018, 1, 10'h008, 3'd4);
    tbl[10] = mk(1, 0, 10'h000, 1, 0, 10'h018, 1, 10'h008, 3'd4);
    tbl[11] = mk(1, 0, 10'h000, 1, 1, 10'h018, 1, 10'h00C, 3'd3);
    tbl[12] = mk(1, 0, 10'h000, 1, 1, 10'h01C, 1, 10'h010, 3'd2);
    tbl[13] = mk(1, 0, 10'h000, 1, 1, 10'h020, 1, 10'h014, 3'd2);
    tbl[14] = mk(1, 0, 10'h000, 0, 1, 10'h024, 1, 10'h018, 3'd2);
    tbl[15] = mk(1, 1, 10'h100, 1, 0, 10'h028, 1, 10'h018, 3'd3);
    tbl[16] = mk(1, 0, 10'h000, 1, 1, 10'h100, 0, 10'h000, 3'd0);
    tbl[17] = mk(1, 0, 10'h000, 1, 1, 10'h104, 0, 10'h000, 3'd0);
    tbl[18] = mk(1, 0, 10'h000, 1, 1, 10'h108, 1, 10'h100, 3'd1);
    tbl[19] = mk(1, 0, 10'h000, 1, 1, 10'h10C, 1, 10'h104, 3'd1);
    tbl[20] = mk(1, 1, 10'h200, 1, 0, 10'h110, 1, 10'h108, 3'd1);
    tbl[21] = mk(1, 1, 10'h3F8, 1, 0, 10'h200, 0, 10'h000, 3'd0);
    tbl[22] = mk(1, 0, 10'h000, 1, 1, 10'h3F8, 0, 10'h000, 3'd0);
    tbl[23] = mk(1, 0, 10'h000, 1, 1, 10'h3FC, 0, 10'h000, 3'd0);
    tbl[24] = mk(1, 0, 10'h000, 1, 1, 10'h000, 1, 10'h3F8, 3'd1);
    tbl[25] = mk(1, 0, 10'h000, 1, 1, 10'h004, 1, 10'h3FC, 3'd1);
    tbl[26] = mk(1, 0, 10'h000, 1, 1, 10'h008, 1, 10'h000, 3'd1);
    tbl[27] = mk(1, 0, 10'h000, 0, 1, 10'h00C, 1, 10'h004, 3'd1);
    tbl[28] = mk(1, 0, 10'h000, 0, 1, 10'h010, 1, 10'h004, 3'd2);
    tbl[29] = mk(1, 0, 10'h000, 0, 0, 10'h014, 1, 10'h004, 3'd3);
    tbl[30] = mk(1, 0, 10'h000, 0, 0, 10'h014, 1, 10'h004, 3'd4);
    tbl[31] = mk(0, 0, 10'h000, 1, 0, 10'h014, 0, 10'h000, 3'd4);
    tbl[32] = mk(0, 0, 10'h000, 1, 0, 10'h000, 0, 10'h000, 3'd0);
    tbl[33] = mk(1, 0, 10'h000, 1, 1, 10'h000, 0, 10'h000, 3'd0);
    tbl[34] = mk(1, 0, 10'h000, 1, 1, 10'h004, 0, 10'h000, 3'd0);
    tbl[35] = mk(1, 0, 10'h000, 1, 1, 10'h008, 1, 10'h000, 3'd1);

    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      rst = tbl[i].rst; redirect = tbl[i].redir;
      redirect_pc = tbl[i].rpc; inst_ready = tbl[i].rdy;
      @(negedge clk);
      check($sformatf("v%0d_imem_en", i), 32'(imem_en), 32'(tbl[i].en));
      check($sformatf("v%0d_imem_addr", i), 32'(imem_addr), 32'(tbl[i].addr));
      check($sformatf("v%0d_inst_valid", i), 32'(inst_valid), 32'(tbl[i].valid));
      check($sformatf("v%0d_queue_count", i), 32'(queue_count), 32'(tbl[i].cnt));
      if (tbl[i].valid) begin
        check($sformatf("v%0d_inst_pc", i), 32'(inst_pc), 32'(tbl[i].ipc));
        check($sformatf("v%0d_inst_data", i), inst_data, 32'(tbl[i].ipc) ^ 32'hA5A5A5A5);
      end
    end

    // Random ready/redirect: delivered stream must be contiguous from each target.
    @(posedge clk);
    #1;
    rst = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    exp_pc = '0;
    delivered = 0;
    for (int c = 0; c < 400; c++) begin
      #1;
      rst = 1'b1;
      redirect = ($urandom_range(0, 15) == 0);
      redirect_pc = ADDR_W'($urandom_range(0, 255) * 4);
      inst_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (inst_valid && inst_ready) begin
        check($sformatf("rnd%0d_inst_pc", c), 32'(inst_pc), 32'(exp_pc));
        check($sformatf("rnd%0d_inst_data", c), inst_data, 32'(exp_pc) ^ 32'hA5A5A5A5);
        exp_pc = exp_pc + ADDR_W'(4);
        delivered++;
      end
      if (redirect) exp_pc = redirect_pc;
      @(posedge clk);
    end
    #1;
    redirect = 1'b0;
    check("rnd_progress", 32'(delivered > 50), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
